// File: rtl/fir_pkg.sv
// Shared sizing helpers for the parametrised FIR datapath.
// Latency: none (compile-time constants and functions only).
// Backpressure: not applicable.
package fir_pkg;

  // Cycles from sample acceptance to the result on out_data.
  localparam int PIPE_LAT = 3;

  // Ceiling log2, used for address and accumulator growth bits.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision signed product width.
  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Accumulator width: product width plus growth for summing all taps.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample, coefficient-write and result bundle for fir_filter_param.
// Latency: none (wires only).
// Backpressure: none; the sink must take every out_valid cycle.
interface fir_filter_param_if
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 8
);
  localparam int ADDR_W = clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  // Source / controller side.
  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  out_valid, out_data, out_sat
  );

  // Filter side.
  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift by FRAC_BITS and saturate to OUT_W.
// Latency: 1 cycle (registered output), value held while in_valid=0.
// Backpressure: none; one result per valid input cycle.
module fir_round_sat #(
  parameter int IN_W      = 20,
  parameter int OUT_W     = 8,
  parameter int FRAC_BITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SW-1:0]    ext;
  logic signed [SW-1:0]    rounded;
  logic signed [SW-1:0]    shifted;
  logic signed [OUT_W-1:0] val;
  logic                    sat;

  assign ext = SW'(in_data);

  // With no fractional bits there is nothing to round away.
  generate
    if (FRAC_BITS > 0) begin : g_rnd
      localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC_BITS - 1);
      assign rounded = ext + RND;
    end else begin : g_nornd
      assign rounded = ext;
    end
  endgenerate

  assign shifted = rounded >>> FRAC_BITS;

  // Clip to the signed output range and note whether clipping happened.
  always_comb begin
    val = shifted[OUT_W-1:0];
    sat = 1'b0;
    if (shifted > MAX_V) begin
      val = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      val = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

  // Register result; data holds across bubbles, sat flag only shows with valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_sat   <= in_valid & sat;
      if (in_valid) out_data <= val;
    end
  end
endmodule

// File: rtl/fir_filter_param.sv
// Pipelined direct-form FIR with run-time writable coefficient bank.
// Latency: 3 cycles from sample acceptance to out_data/out_valid.
// Backpressure: none; bubbles on in_valid pass through as bubbles on out_valid.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 16,
  parameter int OUT_W     = 8,
  parameter int FRAC_BITS = 7
) (
  input logic               clk,
  input logic               rst,
  fir_filter_param_if.slave bus
);
  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [PROD_W-1:0] p [TAPS];
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc;
  logic [PIPE_LAT-1:0]      vld_sr;

  // Delay line advances only on accepted samples; index 0 is the newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (bus.in_valid) begin
      x[0] <= bus.in_data;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
    end
  end

  // Coefficient bank; out-of-range addresses (non power-of-two TAPS) are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) c[k] <= '0;
    end else if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
      c[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Stage 1: per-tap products, so a write landing with a sample already applies to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) p[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) p[k] <= PROD_W'(x[k]) * PROD_W'(c[k]);
    end
  end

  // Adder tree feeding stage 2; ACC_W has enough growth bits to never wrap.
  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < TAPS; k++) acc_sum = acc_sum + ACC_W'(p[k]);
  end

  // Stage 2: register the sum of products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_sum;
  end

  // Valid tracks the sample through delay line, products and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[PIPE_LAT-2:0], bus.in_valid};
  end

  // Stage 3: scale, round and clip into the output register.
  fir_round_sat #(
    .IN_W      (ACC_W),
    .OUT_W     (OUT_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_sr[PIPE_LAT-1]),
    .in_data   (acc),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_sat   (bus.out_sat)
  );
endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: two instances (FRAC_BITS 0 and 7) fed identically.
// Expected results come from an integer model and are queued with their due cycle.
// Every cycle each output is checked against the queue head or for hold/idle.
module tb_fir_filter_param;
  import fir_pkg::*;

  localparam int TAPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_filter_param_if #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8)) bus0 ();
  fir_filter_param_if #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8)) bus7 ();

  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .FRAC_BITS(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .FRAC_BITS(7))
    dut7 (.clk(clk), .rst(rst), .bus(bus7));

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       sat;
  } exp_t;

  exp_t       q0[$];
  exp_t       q7[$];
  int         mx[TAPS];
  int         mc[TAPS];
  logic [7:0] last0;
  logic [7:0] last7;
  int         cyc;
  int         checks;
  int         failures;

  // Reference: exact dot product, round-half-up shift, clip to 8 bits. {sat, data}
  function automatic logic [8:0] model(input int frac);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mc[k]);
    if (frac > 0) r = (acc + (longint'(1) << (frac - 1))) >>> frac;
    else          r = acc;
    if (r > 127)  return {1'b1, 8'h7f};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  task automatic drive(input logic v, input int d, input logic we, input int a, input int cd);
    bus0.in_valid  = v;  bus7.in_valid  = v;
    bus0.in_data   = 8'(d);  bus7.in_data   = 8'(d);
    bus0.coef_we   = we; bus7.coef_we   = we;
    bus0.coef_addr = 4'(a);  bus7.coef_addr = 4'(a);
    bus0.coef_data = 8'(cd); bus7.coef_data = 8'(cd);
  endtask

  task automatic check_dut(input int idx);
    logic       vld;
    logic       sat;
    logic [7:0] dat;
    logic [7:0] last;
    exp_t       e;
    bit         have;
    if (idx == 0) begin
      vld = bus0.out_valid; dat = bus0.out_data; sat = bus0.out_sat; last = last0;
      have = (q0.size() > 0);
      if (have) e = q0[0];
    end else begin
      vld = bus7.out_valid; dat = bus7.out_data; sat = bus7.out_sat; last = last7;
      have = (q7.size() > 0);
      if (have) e = q7[0];
    end
    if (vld) begin
      checks++;
      assert (have && e.cyc == cyc) else begin
        failures++;
        $error("FAIL valid_timing dut%0d cyc=%0d observed out_valid=1 expected_due=%0d queued=%0d",
               idx, cyc, have ? e.cyc : -1, have);
      end
      if (have) begin
        if (idx == 0) void'(q0.pop_front());
        else          void'(q7.pop_front());
        checks++;
        assert (dat === e.data) else begin
          failures++;
          $error("FAIL out_data dut%0d cyc=%0d observed=%0d expected=%0d",
                 idx, cyc, $signed(dat), $signed(e.data));
        end
        checks++;
        assert (sat === e.sat) else begin
          failures++;
          $error("FAIL out_sat dut%0d cyc=%0d observed=%b expected=%b", idx, cyc, sat, e.sat);
        end
      end
      if (idx == 0) last0 = dat;
      else          last7 = dat;
    end else begin
      checks++;
      assert (!(have && e.cyc == cyc)) else begin
        failures++;
        $error("FAIL missing_valid dut%0d cyc=%0d observed out_valid=0 expected=1", idx, cyc);
      end
      if (have && e.cyc == cyc) begin
        if (idx == 0) void'(q0.pop_front());
        else          void'(q7.pop_front());
      end
      checks++;
      assert (sat === 1'b0) else begin
        failures++;
        $error("FAIL idle_sat dut%0d cyc=%0d observed=%b expected=0", idx, cyc, sat);
      end
      checks++;
      assert (dat === last) else begin
        failures++;
        $error("FAIL hold_data dut%0d cyc=%0d observed=%0d expected=%0d",
               idx, cyc, $signed(dat), $signed(last));
      end
    end
  endtask

  // One clock: apply inputs, update model, queue expected results, check outputs.
  task automatic step(input logic v, input int d, input logic we, input int a, input int cd);
    logic [8:0] m;
    exp_t       e;
    drive(v, d, we, a, cd);
    if (we && a < TAPS) mc[a] = cd;
    if (v) begin
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      e.cyc = cyc + 1 + PIPE_LAT;
      m = model(0); e.data = m[7:0]; e.sat = m[8]; q0.push_back(e);
      m = model(7); e.data = m[7:0]; e.sat = m[8]; q7.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    check_dut(0);
    check_dut(1);
    drive(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (bus0.out_valid === 1'b0 && bus7.out_valid === 1'b0) else begin
      failures++;
      $error("FAIL %s_valid observed=%b/%b expected=0/0", tag, bus0.out_valid, bus7.out_valid);
    end
    checks++;
    assert (bus0.out_data === 8'h00 && bus7.out_data === 8'h00) else begin
      failures++;
      $error("FAIL %s_data observed=%0d/%0d expected=0/0", tag,
             $signed(bus0.out_data), $signed(bus7.out_data));
    end
    checks++;
    assert (bus0.out_sat === 1'b0 && bus7.out_sat === 1'b0) else begin
      failures++;
      $error("FAIL %s_sat observed=%b/%b expected=0/0", tag, bus0.out_sat, bus7.out_sat);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    last0 = '0; last7 = '0;
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mc[k] = 0; end
    drive(1'b0, 0, 1'b0, 0, 0);

    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Impulse with c[k]=k+1: 1..16 then 0 on the FRAC_BITS=0 instance.
    for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, k + 1);
    step(1'b1, 1, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0, 0, 0);
    idle(4);

    // Same impulse with a bubble after every sample.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i == 0) ? 1 : 0, 1'b0, 0, 0);
      step(1'b0, 0, 1'b0, 0, 0);
    end
    idle(4);

    // Rounding: c[0]=64, inputs 3, -3, 1, -1 (one bubble between first two).
    for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, (k == 0) ? 64 : 0);
    step(1'b1, 3, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    step(1'b1, -3, 1'b0, 0, 0);
    step(1'b1, 1, 1'b0, 0, 0);
    step(1'b1, -1, 1'b0, 0, 0);
    idle(4);

    // Saturation: all taps 127; full-scale positive, then negative, then a lone 1.
    for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, 127);
    for (int i = 0; i < 16; i++) step(1'b1, 127, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, -128, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0, 0, 0);
    step(1'b1, 1, 1'b0, 0, 0);
    idle(4);

    // Coefficient write in flight: c[0] 1 -> 2 on the same edge as sample 7.
    for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, (k == 0) ? 1 : 0);
    step(1'b1, 5, 1'b0, 0, 0);
    step(1'b1, 7, 1'b1, 0, 2);
    step(1'b1, 9, 1'b0, 0, 0);
    idle(4);

    // Reset with the pipeline full: outputs clear without a clock edge.
    for (int i = 0; i < 5; i++) step(1'b1, 10 + i, 1'b0, 0, 0);
    rst = 1'b1;
    #1;
    check_reset("midreset");
    q0.delete(); q7.delete();
    for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mc[k] = 0; end
    last0 = '0; last7 = '0;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst = 1'b0;

    // Coefficients are zero again, so an impulse yields all-zero valid outputs.
    step(1'b1, 1, 1'b0, 0, 0);
    for (int i = 0; i < 15; i++) step(1'b1, 0, 1'b0, 0, 0);
    idle(5);

    checks++;
    assert (q0.size() == 0 && q7.size() == 0) else begin
      failures++;
      $error("FAIL drained observed=%0d/%0d expected=0/0", q0.size(), q7.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
- Parametrised, pipelined direct-form FIR filter. It is the successor to the fixed 8-bit fir_filter / fir_filter_sep pair.
- Adds configurable data, coefficient and tap widths, and a run-time writable coefficient bank.
- Adds a valid handshake with bubble support, round-half-up scaling, and output saturation with a flag.
- Sits between the sample source and the downstream sink. It consumes one signed sample per valid cycle.

Parameters:
- DATA_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- TAPS, 16, number of taps (>=2).
- OUT_W, 8, signed output width.
- FRAC_BITS, 7, coefficient fractional bits; the result is shifted right by this amount (0 allowed).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  DATA_W  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index to write; index 0 multiplies the newest sample.
- coef_data  in  COEF_W  signed coefficient value.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  OUT_W  signed filtered sample.
- out_sat  out  1  out_data was clipped; meaningful only when out_valid=1, otherwise 0.

Behaviour:
- Reset (async assert, sync-safe deassert): delay line, all pipeline registers and coefficients go to 0; out_valid=0, out_data=0, out_sat=0.
- Delay line x[0..TAPS-1]:
  - On an edge with in_valid=1: x[0]<=in_data and x[k]<=x[k-1].
  - With in_valid=0 it holds, so bubbles do not advance the filter.
- Stage 1 (edge after acceptance): p[k] <= x[k]*c[k], signed, DATA_W+COEF_W bits.
- Stage 2: acc <= sum of p[k].
  - ACC_W = DATA_W+COEF_W+clog2(TAPS); no internal overflow is possible.
- Stage 3: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, with no rounding term when FRAC_BITS=0.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat=1 iff clipping occurred.
- Latency: a sample accepted at edge E0 appears on out_data/out_valid after edge E3, i.e. 3 cycles.
  - Valid travels through a 3-bit shift register alongside the data.
  - Full throughput of 1 sample/cycle; gaps in in_valid reproduce as gaps in out_valid.
- out_data holds its last value while out_valid=0. out_sat is forced to 0 while out_valid=0.
- Coefficient write: c[coef_addr]<=coef_data on an edge with coef_we=1.
  - The new value is used by the stage-1 products on the next edge.
  - A write on the same edge as a sample acceptance therefore applies to that sample and to every later sample.
  - Samples already past stage 1 are unaffected.
  - A coef_addr >= TAPS (non-power-of-two TAPS) is ignored.
- Startup: the delay line is zero after reset, so the first TAPS-1 outputs are partial sums. They are still flagged out_valid=1.
- Reset mid-stream: in-flight samples are discarded (out_valid drops on assertion) and coefficients return to 0. After deassert, the block behaves as freshly reset.
- No backpressure: the sink must accept every out_valid cycle.

Decomposition:
- Package fir_pkg:
  - clog2 function;
  - ACC_W and PROD_W derivation functions;
  - localparam for the pipeline latency (3).
- Sub-module fir_round_sat (params IN_W, OUT_W, FRAC_BITS):
  - registered round-half-up, arithmetic shift and saturate;
  - outputs value and sat flag.
  - It is instantiated once as stage 3 and is reusable by other DSP blocks.

Test Plan:
- Impulse (FRAC_BITS=0, c[k]=k+1): in_data 1 then 15 zeros, all valid -> out_data 1,2,...,16 starting 3 cycles after the first sample, then 0; out_sat=0 throughout.
- Rounding (FRAC_BITS=7, c[0]=64, others 0):
  - in_data 3 -> out_data 2;
  - in_data -3 -> out_data -1;
  - in_data 1 -> out_data 1;
  - in_data -1 -> out_data 0.
- Saturation (all c=127, FRAC_BITS=7):
  - 16 samples of 127 -> last output 127 with out_sat=1;
  - then 16 samples of -128 -> -128 with out_sat=1;
  - a single 1 into a zeroed line -> 1 with out_sat=0.
- Bubbles: impulse scenario with in_valid alternating 1/0 -> the same 1..16 sequence on out_valid cycles only, with out_valid spaced identically to in_valid.
- Coefficient update in flight: write c[0]=2 on the same edge as sample A, with sample B on the next edge, starting from c[0]=1 and other taps 0 -> both A and B are scaled by 2; a sample accepted one edge before the write is scaled by 1.
- Reset mid-operation: assert rst while 3 samples are in flight -> out_valid=0, out_data=0 immediately (async). After release, an impulse with no coefficient writes -> out_data 0.
